interrupt_controller: RTL and testbench

//  Interrupt initiator paired with the multicycle control FSM. Edge-detects external
//  IRQ lines, prioritises and masks them, raises int_req to the control FSM, and on
//  int_ack captures the return PC (EPC) and presents the handler vector for PCData.

---
 rtl/interrupt_controller_if.sv | 45 ++++
 rtl/interrupt_controller.sv | 182 ++++++++++++++++++
 tb/tb_interrupt_controller.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// -----------------------------------------------------------------------------
// interrupt_controller_if
// Purpose : Bundles the signals between the interrupt controller and the rest
//           of the core. These are the external IRQ lines, the mask write port,
//           the PC / acknowledge / return-from-interrupt inputs from the control
//           FSM, and the request, vector and status outputs back to it.
// Modports:
//   master - the core side (control FSM, datapath, IRQ sources). It drives
//            irq, mask_wr, mask_data, pc_in, int_ack and reti.
//   slave  - the interrupt controller. It drives int_req, int_id, int_vector,
//            epc, in_service and pending.
// -----------------------------------------------------------------------------
interface interrupt_controller_if #(
   parameter int NUM_IRQ = 4,
   parameter int ADDR_W  = 16,
   parameter int ID_W    = $clog2(NUM_IRQ)
);

   // core -> controller
   logic [NUM_IRQ-1:0] irq;         // level lines, a rising edge is an event
   logic               mask_wr;     // load the enable register from mask_data
   logic [NUM_IRQ-1:0] mask_data;   // 1 = line enabled
   logic [ADDR_W-1:0]  pc_in;       // current PC, captured as EPC on acknowledge
   logic               int_ack;     // 1-cycle pulse: request accepted
   logic               reti;        // 1-cycle pulse: return from interrupt

   // controller -> core
   logic               int_req;     // request to the control FSM
   logic [ID_W-1:0]    int_id;      // id of the latched request
   logic [ADDR_W-1:0]  int_vector;  // handler address for int_id
   logic [ADDR_W-1:0]  epc;         // return PC captured at acknowledge
   logic               in_service;  // handler currently running
   logic [NUM_IRQ-1:0] pending;     // sticky pending bits, unmasked view

   modport master (
      output irq, mask_wr, mask_data, pc_in, int_ack, reti,
      input  int_req, int_id, int_vector, epc, in_service, pending
   );

   modport slave (
      input  irq, mask_wr, mask_data, pc_in, int_ack, reti,
      output int_req, int_id, int_vector, epc, in_service, pending
   );

endinterface : interrupt_controller_if

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Purpose : Interrupt initiator for the multicycle control FSM. It edge-detects
//           the external IRQ lines into sticky pending bits. It masks them with
//           a software-loadable enable register and picks the lowest-numbered
//           eligible line. It then raises int_req to the control FSM. On int_ack
//           it captures the return PC (EPC) and presents the handler vector.
//           Service is single level: nothing new is requested until reti.
// Ports   :
//   CLK        in   system clock, rising edge
//   Reset      in   synchronous, active-high reset
//   bus.irq        in   NUM_IRQ  external requests (level, rising edge = event)
//   bus.mask_wr    in   1        load enable register from bus.mask_data
//   bus.mask_data  in   NUM_IRQ  1 = line enabled
//   bus.pc_in      in   ADDR_W   current PC from the datapath
//   bus.int_ack    in   1        control FSM accepted the request
//   bus.reti       in   1        control FSM executing return-from-interrupt
//   bus.int_req    out  1        request to control FSM (high in REQ)
//   bus.int_id     out  ID_W     id of the latched request
//   bus.int_vector out  ADDR_W   VEC_BASE + int_id * VEC_STRIDE (truncated)
//   bus.epc        out  ADDR_W   return PC captured at int_ack
//   bus.in_service out  1        high in SERVICE
//   bus.pending    out  NUM_IRQ  sticky pending bits
// -----------------------------------------------------------------------------
module interrupt_controller #(
   parameter int                 NUM_IRQ    = 4,
   parameter int                 ADDR_W     = 16,
   parameter logic [ADDR_W-1:0]  VEC_BASE   = 16'h0100,
   parameter logic [ADDR_W-1:0]  VEC_STRIDE = 16'h0004
) (
   input  logic                   CLK,
   input  logic                   Reset,
   interrupt_controller_if.slave  bus
);

   localparam int ID_W = $clog2(NUM_IRQ);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers and their next-state values
   // ---------------------------------------------------------------------------
   state_t              state_q,      state_d;
   logic [NUM_IRQ-1:0]  irq_q;
   logic [NUM_IRQ-1:0]  pending_q,    pending_d;
   logic [NUM_IRQ-1:0]  enable_q,     enable_d;
   logic [ID_W-1:0]     int_id_q,     int_id_d;
   logic [ADDR_W-1:0]   int_vector_q, int_vector_d;
   logic [ADDR_W-1:0]   epc_q,        epc_d;

   // ---------------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------------
   logic [NUM_IRQ-1:0]  rise;
   logic [NUM_IRQ-1:0]  eligible;
   logic [NUM_IRQ-1:0]  clr;
   logic [ID_W-1:0]     winner;
   logic                take_ack;

   // irq_q resets to zero, so a line already high at the first edge after
   // reset is seen as a rising edge.
   assign rise     = bus.irq & ~irq_q;
   assign eligible = pending_q & enable_q;

   // An acknowledge only counts while a request is outstanding.
   assign take_ack = (state_q == S_REQ) && bus.int_ack;

   // Fixed priority: scan from the top down so that the lowest set index is
   // written last and wins (IRQ 0 is the highest priority).
   always_comb begin
      // NOTE: every signal written in a combinational block gets a default
      // first. Otherwise a path that skips the assignment infers a latch.
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = ID_W'(i);
         end
      end
   end

   // Pending bits are cleared only for the id being acknowledged. A new rising
   // edge on that same line in the same cycle is not lost, because the set
   // term is ORed in after the clear.
   always_comb begin
      clr = '0;
      if (take_ack) begin
         clr[int_id_q] = 1'b1;
      end
   end

   assign pending_d = (pending_q & ~clr) | rise;

   // The new mask is registered, so it only affects arbitration from the
   // following cycle onwards.
   assign enable_d  = bus.mask_wr ? bus.mask_data : enable_q;

   // ---------------------------------------------------------------------------
   // FSM next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      int_id_d     = int_id_q;
      int_vector_d = int_vector_q;
      epc_d        = epc_q;

      unique case (state_q)
         S_IDLE: begin
            if (eligible != '0) begin
               state_d      = S_REQ;
               int_id_d     = winner;
               // Unsigned arithmetic, wraps modulo 2^ADDR_W.
               int_vector_d = VEC_BASE + (ADDR_W'(winner) * VEC_STRIDE);
            end
         end

         S_REQ: begin
            // The id and vector stay frozen while the request is outstanding,
            // even if a higher-priority line arrives meanwhile. Acknowledge
            // takes precedence over withdrawal. A request whose line was
            // masked off is withdrawn, but its pending bit is kept.
            if (bus.int_ack) begin
               state_d = S_SERVICE;
               epc_d   = bus.pc_in;
            end else if (!enable_q[int_id_q]) begin
               state_d = S_IDLE;
            end
         end

         S_SERVICE: begin
            // Interrupts do not nest. New edges only accumulate in pending_q
            // until the handler returns.
            if (bus.reti) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples pre-edge values, whatever order the statements appear in.
      if (Reset) begin
         state_q      <= S_IDLE;
         irq_q        <= '0;
         pending_q    <= '0;
         enable_q     <= '0;
         int_id_q     <= '0;
         int_vector_q <= VEC_BASE;
         epc_q        <= '0;
      end else begin
         state_q      <= state_d;
         irq_q        <= bus.irq;
         pending_q    <= pending_d;
         enable_q     <= enable_d;
         int_id_q     <= int_id_d;
         int_vector_q <= int_vector_d;
         epc_q        <= epc_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: Moore decode of the state plus the holding registers
   // ---------------------------------------------------------------------------
   assign bus.int_req    = (state_q == S_REQ);
   assign bus.in_service = (state_q == S_SERVICE);
   assign bus.int_id     = int_id_q;
   assign bus.int_vector = int_vector_q;
   assign bus.epc        = epc_q;
   assign bus.pending    = pending_q;

endmodule : interrupt_controller

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
// Self-checking bench for interrupt_controller. Inputs change just after the
// falling edge, and outputs are sampled on the falling edge. A monitor pops the
// expected id/vector from a scoreboard each time int_req rises.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

   localparam int NUM_IRQ = 4;
   localparam int ADDR_W  = 16;

   typedef struct {
      logic [1:0]  id;
      logic [15:0] vec;
   } exp_req_t;

   logic     clk;
   logic     rst;
   int       n_checks;
   int       n_fail;
   logic     req_prev;
   logic     any_req;
   exp_req_t sb_q[$];

   interrupt_controller_if #(.NUM_IRQ(NUM_IRQ), .ADDR_W(ADDR_W)) bus ();

   interrupt_controller #(
      .NUM_IRQ   (NUM_IRQ),
      .ADDR_W    (ADDR_W),
      .VEC_BASE  (16'h0100),
      .VEC_STRIDE(16'h0004)
   ) dut (
      .CLK  (clk),
      .Reset(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_exp(input logic [1:0] id, input logic [15:0] vec);
      exp_req_t e;
      e.id  = id;
      e.vec = vec;
      sb_q.push_back(e);
   endtask

   task automatic pulse_ack(input logic [15:0] pc);
      bus.pc_in   = pc;
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
   endtask

   task automatic pulse_reti();
      bus.reti = 1'b1;
      tick();
      bus.reti = 1'b0;
   endtask

   task automatic write_mask(input logic [3:0] m);
      bus.mask_wr   = 1'b1;
      bus.mask_data = m;
      tick();
      bus.mask_wr   = 1'b0;
   endtask

   // Scoreboard monitor: every new request must match the oldest expectation.
   always @(negedge clk) begin
      exp_req_t e;
      if (bus.int_req && !req_prev) begin
         check("req_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_id",  32'(bus.int_id),     32'(e.id));
            check("sb_vec", 32'(bus.int_vector), 32'(e.vec));
         end
      end
      req_prev = bus.int_req;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      req_prev      = 1'b0;
      any_req       = 1'b0;
      rst           = 1'b1;
      bus.irq       = '0;
      bus.mask_wr   = 1'b0;
      bus.mask_data = '0;
      bus.pc_in     = '0;
      bus.int_ack   = 1'b0;
      bus.reti      = 1'b0;

      // 1: reset values, then quiet for 20 cycles
      tick(3);
      check("rst_int_req",    32'(bus.int_req),    32'd0);
      check("rst_in_service", 32'(bus.in_service), 32'd0);
      check("rst_int_id",     32'(bus.int_id),     32'd0);
      check("rst_vector",     32'(bus.int_vector), 32'h0100);
      check("rst_epc",        32'(bus.epc),        32'd0);
      check("rst_pending",    32'(bus.pending),    32'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         any_req = any_req | bus.int_req;
      end
      check("idle_20_no_req", 32'(any_req), 32'd0);

      // 2: single request, two-cycle latency, acknowledge
      write_mask(4'b1111);
      push_exp(2'd2, 16'h0108);
      bus.irq = 4'b0100;
      tick();
      check("t2_pending_k", 32'(bus.pending), 32'h4);
      check("t2_req_k",     32'(bus.int_req), 32'd0);
      tick();
      check("t2_req_k1",    32'(bus.int_req),    32'd1);
      check("t2_id",        32'(bus.int_id),     32'd2);
      check("t2_vec",       32'(bus.int_vector), 32'h0108);
      pulse_ack(16'h0042);
      check("t2_in_service", 32'(bus.in_service), 32'd1);
      check("t2_req_low",    32'(bus.int_req),    32'd0);
      check("t2_epc",        32'(bus.epc),        32'h0042);
      check("t2_pending_clr", 32'(bus.pending),   32'd0);
      bus.irq = 4'b0000;
      pulse_reti();
      check("t2_idle", 32'(bus.in_service), 32'd0);

      // 3: simultaneous edges, priority, re-request after reti
      push_exp(2'd1, 16'h0104);
      push_exp(2'd3, 16'h010C);
      bus.irq = 4'b1010;
      tick(2);
      check("t3_req",  32'(bus.int_req),    32'd1);
      check("t3_id1",  32'(bus.int_id),     32'd1);
      check("t3_vec1", 32'(bus.int_vector), 32'h0104);
      pulse_ack(16'h0050);
      check("t3_epc", 32'(bus.epc), 32'h0050);
      bus.irq = 4'b0000;
      pulse_reti();
      check("t3_after_r_req", 32'(bus.int_req),    32'd0);
      check("t3_after_r_svc", 32'(bus.in_service), 32'd0);
      tick();
      check("t3_r1_req",  32'(bus.int_req),    32'd1);
      check("t3_id3",     32'(bus.int_id),     32'd3);
      check("t3_vec3",    32'(bus.int_vector), 32'h010C);
      pulse_ack(16'h0060);
      pulse_reti();

      // 4: no nesting, ack ignored in SERVICE
      push_exp(2'd2, 16'h0108);
      bus.irq = 4'b0100;
      tick(2);
      check("t4_id2", 32'(bus.int_id), 32'd2);
      pulse_ack(16'h0070);
      check("t4_in_service", 32'(bus.in_service), 32'd1);
      push_exp(2'd0, 16'h0100);
      bus.irq = 4'b0101;
      tick();
      bus.pc_in = 16'h0BAD;
      pulse_ack(16'h0BAD);
      tick(2);
      check("t4_svc_hold",   32'(bus.in_service), 32'd1);
      check("t4_no_req",     32'(bus.int_req),    32'd0);
      check("t4_epc_hold",   32'(bus.epc),        32'h0070);
      check("t4_pending0",   32'(bus.pending),    32'h1);
      pulse_reti();
      check("t4_after_r_req", 32'(bus.int_req), 32'd0);
      tick();
      check("t4_req0", 32'(bus.int_req), 32'd1);
      check("t4_id0",  32'(bus.int_id),  32'd0);
      pulse_ack(16'h0080);
      pulse_reti();
      bus.irq = 4'b0000;

      // 5: masked lines accumulate, unmask raises, mask withdraws a request
      write_mask(4'b0000);
      bus.irq = 4'b0010;
      tick(3);
      check("t5_pending", 32'(bus.pending), 32'h2);
      check("t5_no_req",  32'(bus.int_req), 32'd0);
      push_exp(2'd1, 16'h0104);
      write_mask(4'b0010);
      check("t5_mask_lat", 32'(bus.int_req), 32'd0);
      tick();
      check("t5_req",  32'(bus.int_req), 32'd1);
      check("t5_id1",  32'(bus.int_id),  32'd1);
      write_mask(4'b0000);
      check("t5_req_hold", 32'(bus.int_req), 32'd1);
      tick();
      check("t5_withdrawn",  32'(bus.int_req), 32'd0);
      check("t5_pend_kept",  32'(bus.pending), 32'h2);
      push_exp(2'd1, 16'h0104);
      write_mask(4'b1111);
      tick();
      check("t5_rereq", 32'(bus.int_req), 32'd1);
      pulse_ack(16'h1234);
      check("t5_svc", 32'(bus.in_service), 32'd1);
      check("t5_epc", 32'(bus.epc),        32'h1234);

      // 6: reset in SERVICE abandons everything; held lines re-trigger
      bus.irq = 4'b1010;
      tick();
      check("t6_pending", 32'(bus.pending), 32'h8);
      rst = 1'b1;
      tick();
      check("t6_svc",     32'(bus.in_service), 32'd0);
      check("t6_req",     32'(bus.int_req),    32'd0);
      check("t6_epc",     32'(bus.epc),        32'd0);
      check("t6_pending_rst", 32'(bus.pending), 32'd0);
      check("t6_vec",     32'(bus.int_vector), 32'h0100);
      check("t6_id",      32'(bus.int_id),     32'd0);
      rst = 1'b0;
      tick();
      check("t6_post_rise", 32'(bus.pending), 32'hA);
      tick();
      check("t6_masked_no_req", 32'(bus.int_req), 32'd0);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_interrupt_controller
